// File: rtl/jk_input_conditioner.sv
// Input front end for the JK flip-flop demo: synchronizes and debounces the raw
// J/K buttons, flags rising edges, and emits the step strobe plus a J/K sample latch.
`timescale 1ns/1ps
module jk_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 50_000_000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic J_raw,
    input  logic K_raw,
    output logic J,
    output logic K,
    output logic J_rise,
    output logic K_rise,
    output logic Tick,
    output logic J_lat,
    output logic K_lat
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(TICK_CYCLES);

    // Channel index 0 is J, index 1 is K.
    logic [1:0]    raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    rise_q, rise_d;
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tick_q, tick_d;
    logic [1:0]    lat_q, lat_d;
    logic          tick_wrap;

    assign raw = {K_raw, J_raw};

    // A mismatch must persist DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]  = deb_q[i];
            rise_d[i] = 1'b0;
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i]  = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign tick_wrap = (tcnt_q == TW'(TICK_CYCLES - 1));

    // The latch samples the pre-update debounced value on the edge where Tick is high.
    always_comb begin
        tcnt_d = tick_wrap ? '0 : tcnt_q + 1'b1;
        tick_d = tick_wrap;
        lat_d  = tick_q ? deb_q : lat_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            rise_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= '0;
            end
            tcnt_q  <= '0;
            tick_q  <= 1'b0;
            lat_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
            tcnt_q  <= tcnt_d;
            tick_q  <= tick_d;
            lat_q   <= lat_d;
        end
    end

    assign J      = deb_q[0];
    assign K      = deb_q[1];
    assign J_rise = rise_q[0];
    assign K_rise = rise_q[1];
    assign Tick   = tick_q;
    assign J_lat  = lat_q[0];
    assign K_lat  = lat_q[1];

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Directed bench for jk_input_conditioner with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
// Variable e is the rising-edge index since the latest reset release.
`timescale 1ns/1ps
module tb_jk_input_conditioner;

    logic Clk;
    logic Rst_n;
    logic J_raw, K_raw;
    logic J, K, J_rise, K_rise, Tick, J_lat, K_lat;

    int n_tests = 0;
    int n_fail  = 0;
    int e       = 0;
    int nxt     = 0;

    jk_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (8)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .J_raw (J_raw),
        .K_raw (K_raw),
        .J     (J),
        .K     (K),
        .J_rise(J_rise),
        .K_rise(K_rise),
        .Tick  (Tick),
        .J_lat (J_lat),
        .K_lat (K_lat)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
        e++;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: edge %0d observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_J"},      J,      1'b0);
        check({tag, "_K"},      K,      1'b0);
        check({tag, "_J_rise"}, J_rise, 1'b0);
        check({tag, "_K_rise"}, K_rise, 1'b0);
        check({tag, "_Tick"},   Tick,   1'b0);
        check({tag, "_J_lat"},  J_lat,  1'b0);
        check({tag, "_K_lat"},  K_lat,  1'b0);
    endtask

    initial begin
        Rst_n = 1'b0;
        J_raw = 1'b1;
        K_raw = 1'b1;
        #1;
        check_zero("rst_t0");
        repeat (3) begin
            step();
            check_zero("rst_hold");
        end

        // Reset release, tick period, power-up debounce of J=K=1.
        Rst_n = 1'b1;
        e = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check("t1_tick",   Tick,   (e % 8) == 0);
            check("t1_j",      J,      e >= 6);
            check("t1_k",      K,      e >= 6);
            check("t1_j_rise", J_rise, e == 6);
            check("t1_k_rise", K_rise, e == 6);
            check("t1_j_lat",  J_lat,  e >= 9);
            check("t1_k_lat",  K_lat,  e >= 9);
        end

        // Clean fall then clean rise on J.
        J_raw = 1'b0;
        for (int i = 17; i <= 33; i++) begin
            step();
            if (e == 22) J_raw = 1'b1;
            check("t2_j",      J,      (e < 22) || (e >= 28));
            check("t2_j_rise", J_rise, e == 28);
            check("t2_j_lat",  J_lat,  (e < 25) || (e >= 33));
            check("t2_k",      K,      1'b1);
        end

        // Drop J, then bounce 1,1,1,0,1,1,1,1 and hold 1.
        for (int i = 34; i <= 51; i++) begin
            nxt = e + 1;
            J_raw = (nxt >= 41) && (nxt != 44);
            step();
            check("t3_j",      J,      (e < 39) || (e >= 50));
            check("t3_j_rise", J_rise, e == 50);
        end

        // Three-cycle glitches 0,0,0,1 twice against J=1.
        for (int i = 52; i <= 63; i++) begin
            nxt = e + 1;
            J_raw = (nxt == 55) || (nxt >= 59);
            step();
            check("t3_glitch_j",    J,      1'b1);
            check("t3_glitch_rise", J_rise, 1'b0);
        end

        // Latch alignment, including J updating on the capture edge 81.
        for (int i = 64; i <= 89; i++) begin
            nxt = e + 1;
            J_raw = (nxt >= 76);
            step();
            check("t4_tick",  Tick,  (e % 8) == 0);
            check("t4_j",     J,     (e < 69) || (e >= 81));
            check("t4_j_lat", J_lat, (e < 73) || (e >= 89));
            check("t4_k_lat", K_lat, 1'b1);
        end

        // Both channels fall, then rise together.
        for (int i = 90; i <= 103; i++) begin
            nxt = e + 1;
            J_raw = (nxt >= 97);
            K_raw = (nxt >= 97);
            step();
            check("t5_j",      J,      (e < 95) || (e >= 102));
            check("t5_k",      K,      (e < 95) || (e >= 102));
            check("t5_j_rise", J_rise, e == 102);
            check("t5_k_rise", K_rise, e == 102);
        end

        // Start a J fall so its counter is 2 and the tick counter 5 after edge 109.
        for (int i = 104; i <= 109; i++) begin
            nxt = e + 1;
            J_raw = (nxt < 106);
            step();
            check("t6_pre_j", J, 1'b1);
        end
        check("t6_pre_j_lat", J_lat, 1'b1);
        check("t6_pre_k_lat", K_lat, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        J_raw = 1'b1;
        K_raw = 1'b1;
        repeat (2) begin
            step();
            check_zero("t6_hold");
        end
        Rst_n = 1'b1;
        e = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            check("t6_j",      J,      e >= 6);
            check("t6_k",      K,      e >= 6);
            check("t6_j_rise", J_rise, e == 6);
            check("t6_tick",   Tick,   e == 8);
            check("t6_j_lat",  J_lat,  e >= 9);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_input_conditioner.md
Name: jk_input_conditioner

Overview:
- Front-end stage for the JK flip-flop demo. It takes two raw, bouncy, asynchronous pushbutton/switch inputs and produces clean J and K levels for the flip-flop stage.
- Also generates the slow step strobe (Tick) that the flip-flop stage uses as its clock enable.
- Presents a J/K pair that is sampled at Tick, so both inputs change together from the flip-flop's point of view.
- Contains a two-flop synchronizer, a per-channel debounce counter, edge detection, a step-rate counter and a sample latch.

Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive cycles a synchronized input must differ from its debounced value before the debounced value flips. Must be >= 1.
- TICK_CYCLES, default 50_000_000: period of Tick in Clk cycles. Must be >= 2.
- Counter widths are derived internally from the parameters. No width parameter is exposed.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- J_raw  in  1  raw J input, asynchronous to Clk, may bounce.
- K_raw  in  1  raw K input, asynchronous to Clk, may bounce.
- J  out  1  debounced J level.
- K  out  1  debounced K level.
- J_rise  out  1  one-cycle pulse on a 0->1 transition of J.
- K_rise  out  1  one-cycle pulse on a 0->1 transition of K.
- Tick  out  1  one-cycle step strobe, period TICK_CYCLES.
- J_lat  out  1  J value captured at the most recent Tick.
- K_lat  out  1  K value captured at the most recent Tick.

Behaviour:
- Reset (Rst_n low, takes effect asynchronously) clears all of the following to 0:
  - synchronizer flops;
  - debounce counters;
  - tick counter;
  - every output (J, K, J_rise, K_rise, Tick, J_lat, K_lat).
- Synchronizer: each raw input passes through two flops. The synchronized value lags the raw input by 2 edges.
- Debounce, per channel, evaluated every edge:
  - If sync == debounced: counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: debounced <= sync and counter <= 0.
  - Otherwise: counter <= counter+1.
  - A single cycle of agreement (bounce back) restarts the count.
  - Latency from a clean raw step to the J/K change is 2 + DEBOUNCE_CYCLES edges.
- Edge pulses:
  - J_rise is high for exactly the first cycle in which J reads 1 after having been 0. K_rise is the same for K.
  - They are registered in the same edge that updates J/K.
  - No pulse on a 1->0 transition.
  - No pulse at reset release.
- Tick:
  - The counter runs 0..TICK_CYCLES-1 and wraps to 0.
  - Tick is registered. It is high for the single cycle after the edge on which the counter wraps.
  - The first Tick is high in the cycle after the TICK_CYCLES-th rising edge following Rst_n deassertion.
  - After that, Tick repeats every TICK_CYCLES cycles with no drift.
- Latch:
  - On every edge where Tick is high: J_lat <= J and K_lat <= K. Otherwise both hold their value.
  - If J/K update on the same edge as the capture, the latch takes the pre-update value.
  - J_lat and K_lat therefore only ever change together, one cycle after Tick is sampled high.
- Channels are independent. Simultaneous J and K transitions are each handled on their own counters and may produce J_rise and K_rise in the same cycle.
- Reset asserted mid-debounce or mid-tick aborts immediately. After release, behaviour is identical to power-up: no pending transition is remembered.
- No combinational path from any input to any output.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and TICK_CYCLES=8.
1. Reset and Tick period: hold Rst_n low for 3 cycles with J_raw=K_raw=1, then release.
   -> All outputs are 0 during reset.
   -> The first Tick is in the cycle after edge 8 following release. Further Ticks follow every 8 cycles.
   -> J=K=1 after edge 6 (2+4). J_rise=K_rise=1 for that single cycle.
2. Clean step: J_raw goes 0->1 and is held.
   -> J goes high exactly 6 edges later.
   -> J_rise is high for 1 cycle.
   -> J_raw going 1->0 drops J 6 edges later with no pulse.
3. Bounce rejection: J_raw pattern 1,1,1,0,1,1,1,1 (one cycle each), then held at 1.
   -> The debounce count restarts at the 0. J rises only after 4 uninterrupted mismatch cycles.
   -> 3-cycle glitches (1,1,1,0…) never change J.
4. Latch alignment: change J at an arbitrary phase relative to Tick.
   -> J_lat reflects J only after the next Tick.
   -> J_lat and K_lat never change except one cycle after Tick.
   -> If J changes on the capture edge, J_lat keeps the old value until the following Tick.
5. Simultaneous inputs: J_raw and K_raw rise in the same cycle.
   -> J and K rise together 6 edges later. J_rise and K_rise pulse in the same cycle.
6. Reset mid-operation: assert Rst_n low asynchronously (between edges) with the debounce counter at 2 and the tick counter at 5.
   -> Outputs clear immediately.
   -> After release, J needs a full 6 edges and the next Tick needs a full 8 edges.
